ocp_master_port: RTL and testbench
==================================

OCP_MASTER_PORT -- requirements
Module: ocp_master_port

Interface
REQ-001 Parameters, one per line: name, default, meaning.
- ADDR_WIDTH, 64, MAddr and req_addr width.
- DATA_WIDTH, 8, MData, SData, req_wdata and rsp_data width.
- FIFO_DEPTH, 4, request FIFO entries; power of two, 2 or more.
- MAX_OUTST, 4, maximum reads in flight; 1 or more.
REQ-002 Ports, one per line: name, direction, width, meaning.
- Clk, in, 1, clock.
- reset, in, 1, reset; synchronous, active-high, clock Clk.
- EnableClk, in, 1, OCP clock enable.
- req_valid, in, 1, bridge request valid.
- req_ready, out, 1, bridge request accepted.
- req_write, in, 1, 1 = write, 0 = read.
- req_addr, in, ADDR_WIDTH, request address.
- req_wdata, in, DATA_WIDTH, write data.
- rsp_valid, out, 1, read response valid.
- rsp_ready, in, 1, bridge consumes the response.
- rsp_data, out, DATA_WIDTH, read data.
- rsp_err, out, 1, the response was FAIL or ERR.
- busy, out, 1, FIFO non-empty, FSM not IDLE, or reads outstanding.
- err_unexpected, out, 1, sticky flag: response arrived with none outstanding.
- MCmd, out, 3, OCP command.
- MAddr, out, ADDR_WIDTH, OCP address.
- MData, out, DATA_WIDTH, OCP write data.
- MDataValid, out, 1, OCP data valid.
- MRespAccept, out, 1, OCP response accept.
- SCmdAccept, in, 1, slave accepts the command.
- SDataAccept, in, 1, slave accepts the data.
- SResp, in, 2, slave response.
- SData, in, DATA_WIDTH, slave read data.

Function
REQ-003 Encodings: MCmd IDLE=000, WR=001, RD=010. SResp NULL=00, DVA=01, FAIL=10, ERR=11.
REQ-004 Request FIFO push: occurs on every Clk edge where req_valid && req_ready, independent of EnableClk. req_ready = FIFO not full.
REQ-005 OCP-side gating: FSM, FIFO pop, outstanding counter and response capture SHALL update only on edges where EnableClk=1.
REQ-006 FSM states: IDLE, RD_CMD, WR_CD, WR_D, WR_C. All OCP outputs SHALL be registered.
REQ-007 Issue: in IDLE, with FIFO non-empty and (head is a write, or outstanding < MAX_OUTST), the FSM pops the head and enters RD_CMD or WR_CD.
- MCmd/MAddr are valid in the cycle after the pop edge.
- A request accepted at edge N appears on MCmd after edge N+1 at the earliest.
REQ-008 RD_CMD: drive MCmd=RD and MAddr; hold them until SCmdAccept=1 is sampled; the outstanding count increments on that edge.
REQ-009 WR_CD: drive MCmd=WR, MAddr, MData and MDataValid=1. Transitions:
- SCmdAccept && SDataAccept: write complete.
- SCmdAccept only: go to WR_D (MCmd=IDLE, MData and MDataValid held).
- SDataAccept only: go to WR_C (MCmd and MAddr held, MDataValid=0).
REQ-010 WR_D exits on SDataAccept; WR_C exits on SCmdAccept. Writes are posted and expect no response.
REQ-011 On completion of a command, the FSM SHALL apply the REQ-007 issue rule on the same edge, giving back-to-back commands with no IDLE cycle. Otherwise it returns to IDLE.
REQ-012 Idle output values: MCmd=IDLE, MAddr=0, MData=0, MDataValid=0. Never X.
REQ-013 Response capture:
- MRespAccept = !rsp_valid || rsp_ready.
- When SResp != NULL and MRespAccept=1 (EnableClk=1): load rsp_data=SData, set rsp_err = (SResp != DVA), set rsp_valid=1, and decrement outstanding.
- rsp_valid clears on rsp_ready when no new response is loaded.
REQ-014 Simultaneous read-command accept and response accept SHALL leave the outstanding count unchanged.
REQ-015 A response accepted while outstanding=0 SHALL set err_unexpected and SHALL NOT decrement the count below 0. err_unexpected clears only on reset.
REQ-016 With outstanding=MAX_OUTST, a read at the FIFO head SHALL stall; writes behind it SHALL NOT bypass it (strict order).

Reset
REQ-017 reset SHALL act on the Clk edge regardless of EnableClk.
- FIFO flushed; FSM to IDLE; outstanding cleared.
- Outputs: REQ-012 values; rsp_valid=0, rsp_data=0, rsp_err=0, err_unexpected=0, MRespAccept=1, busy=0.
- req_ready=1 after reset.
REQ-018 Reset mid-transaction SHALL abandon the command in flight. Responses arriving after reset with outstanding=0 SHALL set err_unexpected per REQ-015.

Structure
REQ-019 Package ocp_pkg SHALL hold the MCmd and SResp encodings and the FSM state type.
REQ-020 The request FIFO SHALL be sub-module ocp_req_fifo: synchronous, parametrised width and depth, with full and empty outputs and one-cycle read.

Verification
REQ-021 Read with slave stall: one read at addr 0x10, SCmdAccept low for 3 cycles.
- Response: MCmd=RD held 3 cycles.
- SResp=DVA with SData=0xA5 gives rsp_valid=1, rsp_data=0xA5, rsp_err=0.
REQ-022 Split write: write 0x3C to 0x20 with SCmdAccept in cycle 1 and SDataAccept in cycle 3.
- Response: WR_CD, then WR_D; MDataValid high through cycle 3; MCmd=IDLE from cycle 2.
REQ-023 Back-to-back and limit: 6 reads, MAX_OUTST=4, SCmdAccept always 1, no responses.
- Response: exactly 4 RD issued consecutively, then a stall.
- One DVA releases one more RD.
REQ-024 Response backpressure: rsp_ready=0 with two responses pending.
- Response: MRespAccept=0 after the first is captured; the second is captured the cycle after rsp_ready=1.
- SResp=ERR gives rsp_err=1.
REQ-025 Full FIFO and enable gating: EnableClk=0, push FIFO_DEPTH requests.
- Response: req_ready=0 after 4 pushes; MCmd stays IDLE.
- Assert reset mid-issue: all REQ-017 values on the next edge.

Source files
------------

// File: rtl/ocp_pkg.sv
// Shared OCP encodings (MCmd, SResp) and the master-port FSM state type.
package ocp_pkg;

  typedef enum logic [2:0] {
    MCMD_IDLE = 3'b000,
    MCMD_WR   = 3'b001,
    MCMD_RD   = 3'b010
  } mcmd_e;

  typedef enum logic [1:0] {
    SRESP_NULL = 2'b00,
    SRESP_DVA  = 2'b01,
    SRESP_FAIL = 2'b10,
    SRESP_ERR  = 2'b11
  } sresp_e;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_RD_CMD,
    ST_WR_CD,
    ST_WR_D,
    ST_WR_C
  } state_e;

endpackage

// File: rtl/ocp_req_fifo.sv
// Synchronous request FIFO, show-ahead head; push is ignored when full and pop when empty.
// Data pushed on an edge is visible at the head after that edge (one-cycle read).
module ocp_req_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic             Clk,
  input  logic             reset,
  input  logic             push,
  input  logic [WIDTH-1:0] push_dat,
  input  logic             pop,
  output logic [WIDTH-1:0] head_dat,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] PTR_ONE = (AW + 1)'(1);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW:0]      wr_ptr_q, wr_ptr_d;
  logic [AW:0]      rd_ptr_q, rd_ptr_d;
  logic             do_push, do_pop;

  // Pointers carry one extra wrap bit so full and empty are distinguishable.
  assign empty    = (wr_ptr_q == rd_ptr_q);
  assign full     = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign do_push  = push && !full;
  assign do_pop   = pop && !empty;
  assign head_dat = mem_q[rd_ptr_q[AW-1:0]];

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (do_push) wr_ptr_d = wr_ptr_q + PTR_ONE;
    if (do_pop)  rd_ptr_d = rd_ptr_q + PTR_ONE;
  end

  always_ff @(posedge Clk) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  always_ff @(posedge Clk) begin
    if (do_push) mem_q[wr_ptr_q[AW-1:0]] <= push_dat;
  end

endmodule

// File: rtl/ocp_master_port.sv
// Bridge-to-OCP master: queues requests, issues them in order with registered OCP outputs.
// A request reaches MCmd one edge after acceptance at the earliest; reads stall at MAX_OUTST.
module ocp_master_port
  import ocp_pkg::*;
#(
  parameter int ADDR_WIDTH = 64,
  parameter int DATA_WIDTH = 8,
  parameter int FIFO_DEPTH = 4,
  parameter int MAX_OUTST  = 4
) (
  input  logic                  Clk,
  input  logic                  reset,
  input  logic                  EnableClk,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_write,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [DATA_WIDTH-1:0] req_wdata,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [DATA_WIDTH-1:0] rsp_data,
  output logic                  rsp_err,
  output logic                  busy,
  output logic                  err_unexpected,
  output logic [2:0]            MCmd,
  output logic [ADDR_WIDTH-1:0] MAddr,
  output logic [DATA_WIDTH-1:0] MData,
  output logic                  MDataValid,
  output logic                  MRespAccept,
  input  logic                  SCmdAccept,
  input  logic                  SDataAccept,
  input  logic [1:0]            SResp,
  input  logic [DATA_WIDTH-1:0] SData
);

  localparam int OW = $clog2(MAX_OUTST + 1);
  localparam logic [OW-1:0] OUT_MAX = OW'(MAX_OUTST);
  localparam logic [OW-1:0] OUT_ONE = OW'(1);

  typedef struct packed {
    logic                  wr;
    logic [ADDR_WIDTH-1:0] addr;
    logic [DATA_WIDTH-1:0] wdata;
  } req_t;

  req_t                  push_req, head_req;
  logic                  fifo_full, fifo_empty, pop, cmd_done, can_issue;
  logic                  cmd_acc, resp_acc, resp_dec;
  state_e                state_q, state_d;
  mcmd_e                 mcmd_q, mcmd_d;
  logic [ADDR_WIDTH-1:0] maddr_q, maddr_d;
  logic [DATA_WIDTH-1:0] mdata_q, mdata_d;
  logic                  mdval_q, mdval_d;
  logic [OW-1:0]         outst_q, outst_d;
  logic                  rsp_valid_q, rsp_valid_d;
  logic [DATA_WIDTH-1:0] rsp_data_q, rsp_data_d;
  logic                  rsp_err_q, rsp_err_d;
  logic                  err_unexp_q, err_unexp_d;

  assign push_req = '{wr: req_write, addr: req_addr, wdata: req_wdata};
  assign req_ready = !fifo_full;

  ocp_req_fifo #(
    .WIDTH ($bits(req_t)),
    .DEPTH (FIFO_DEPTH)
  ) u_req_fifo (
    .Clk      (Clk),
    .reset    (reset),
    .push     (req_valid && req_ready),
    .push_dat (push_req),
    .pop      (pop),
    .head_dat (head_req),
    .full     (fifo_full),
    .empty    (fifo_empty)
  );

  assign MRespAccept = !rsp_valid_q || rsp_ready;
  assign cmd_acc     = EnableClk && (state_q == ST_RD_CMD) && SCmdAccept;
  assign resp_acc    = EnableClk && (SResp != SRESP_NULL) && MRespAccept;
  assign resp_dec    = resp_acc && (outst_q != '0);

  always_comb begin
    outst_d = outst_q;
    if (cmd_acc && !resp_dec)      outst_d = outst_q + OUT_ONE;
    else if (!cmd_acc && resp_dec) outst_d = outst_q - OUT_ONE;
  end

  // Uses the post-edge count so a read accepted this edge is counted before the next issues.
  assign can_issue = !fifo_empty && (head_req.wr || (outst_d < OUT_MAX));

  always_comb begin
    state_d  = state_q;
    mcmd_d   = mcmd_q;
    maddr_d  = maddr_q;
    mdata_d  = mdata_q;
    mdval_d  = mdval_q;
    pop      = 1'b0;
    cmd_done = 1'b0;
    if (EnableClk) begin
      case (state_q)
        ST_IDLE:   cmd_done = 1'b1;
        ST_RD_CMD: cmd_done = SCmdAccept;
        ST_WR_CD: begin
          if (SCmdAccept && SDataAccept) begin
            cmd_done = 1'b1;
          end else if (SCmdAccept) begin
            state_d = ST_WR_D;
            mcmd_d  = MCMD_IDLE;
            maddr_d = '0;
          end else if (SDataAccept) begin
            state_d = ST_WR_C;
            mdval_d = 1'b0;
            mdata_d = '0;
          end
        end
        ST_WR_D:   cmd_done = SDataAccept;
        ST_WR_C:   cmd_done = SCmdAccept;
        default:   cmd_done = 1'b1;
      endcase
      if (cmd_done) begin
        if (can_issue) begin
          pop     = 1'b1;
          maddr_d = head_req.addr;
          if (head_req.wr) begin
            state_d = ST_WR_CD;
            mcmd_d  = MCMD_WR;
            mdata_d = head_req.wdata;
            mdval_d = 1'b1;
          end else begin
            state_d = ST_RD_CMD;
            mcmd_d  = MCMD_RD;
            mdata_d = '0;
            mdval_d = 1'b0;
          end
        end else begin
          state_d = ST_IDLE;
          mcmd_d  = MCMD_IDLE;
          maddr_d = '0;
          mdata_d = '0;
          mdval_d = 1'b0;
        end
      end
    end
  end

  // The bridge-side consume is not gated by EnableClk, so one handshake drains exactly one response.
  always_comb begin
    rsp_valid_d = rsp_valid_q && !rsp_ready;
    rsp_data_d  = rsp_data_q;
    rsp_err_d   = rsp_err_q;
    err_unexp_d = err_unexp_q;
    if (resp_acc) begin
      rsp_valid_d = 1'b1;
      rsp_data_d  = SData;
      rsp_err_d   = (SResp != SRESP_DVA);
      if (outst_q == '0) err_unexp_d = 1'b1;
    end
  end

  always_ff @(posedge Clk) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      mcmd_q      <= MCMD_IDLE;
      maddr_q     <= '0;
      mdata_q     <= '0;
      mdval_q     <= 1'b0;
      outst_q     <= '0;
      rsp_valid_q <= 1'b0;
      rsp_data_q  <= '0;
      rsp_err_q   <= 1'b0;
      err_unexp_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      mcmd_q      <= mcmd_d;
      maddr_q     <= maddr_d;
      mdata_q     <= mdata_d;
      mdval_q     <= mdval_d;
      outst_q     <= outst_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_data_q  <= rsp_data_d;
      rsp_err_q   <= rsp_err_d;
      err_unexp_q <= err_unexp_d;
    end
  end

  assign MCmd           = mcmd_q;
  assign MAddr          = maddr_q;
  assign MData          = mdata_q;
  assign MDataValid     = mdval_q;
  assign rsp_valid      = rsp_valid_q;
  assign rsp_data       = rsp_data_q;
  assign rsp_err        = rsp_err_q;
  assign err_unexpected = err_unexp_q;
  assign busy           = !fifo_empty || (state_q != ST_IDLE) || (outst_q != '0);

endmodule

// File: tb/tb_ocp_master_port.sv
// Directed bench for ocp_master_port acting as the OCP slave; read responses go through a scoreboard queue.
module tb_ocp_master_port;

  logic        Clk = 1'b0;
  logic        reset, EnableClk;
  logic        req_valid, req_ready, req_write;
  logic [63:0] req_addr;
  logic [7:0]  req_wdata;
  logic        rsp_valid, rsp_ready, rsp_err, busy, err_unexpected;
  logic [7:0]  rsp_data;
  logic [2:0]  MCmd;
  logic [63:0] MAddr;
  logic [7:0]  MData;
  logic        MDataValid, MRespAccept, SCmdAccept, SDataAccept;
  logic [1:0]  SResp;
  logic [7:0]  SData;

  int          n_cmp = 0;
  int          n_err = 0;
  logic [8:0]  rsp_q [$];
  logic [63:0] addr_q [$];
  int          rd_cnt, first_rd, last_rd;

  always #5 Clk = ~Clk;

  ocp_master_port dut (
    .Clk            (Clk),
    .reset          (reset),
    .EnableClk      (EnableClk),
    .req_valid      (req_valid),
    .req_ready      (req_ready),
    .req_write      (req_write),
    .req_addr       (req_addr),
    .req_wdata      (req_wdata),
    .rsp_valid      (rsp_valid),
    .rsp_ready      (rsp_ready),
    .rsp_data       (rsp_data),
    .rsp_err        (rsp_err),
    .busy           (busy),
    .err_unexpected (err_unexpected),
    .MCmd           (MCmd),
    .MAddr          (MAddr),
    .MData          (MData),
    .MDataValid     (MDataValid),
    .MRespAccept    (MRespAccept),
    .SCmdAccept     (SCmdAccept),
    .SDataAccept    (SDataAccept),
    .SResp          (SResp),
    .SData          (SData)
  );

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_err++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic check_rsp(input string tag);
    logic [8:0] e;
    if (rsp_q.size() == 0) begin
      n_cmp++;
      n_err++;
      $error("FAIL %s: observed empty scoreboard expected a queued response", tag);
    end else begin
      e = rsp_q.pop_front();
      chk({tag, "_vld"}, 64'(rsp_valid), 64'd1);
      chk({tag, "_dat"}, 64'(rsp_data), 64'(e[7:0]));
      chk({tag, "_err"}, 64'(rsp_err), 64'(e[8]));
    end
  endtask

  task automatic check_reset_state(input string tag);
    chk({tag, "_mcmd"}, 64'(MCmd), 64'd0);
    chk({tag, "_maddr"}, MAddr, 64'd0);
    chk({tag, "_mdata"}, 64'(MData), 64'd0);
    chk({tag, "_mdv"}, 64'(MDataValid), 64'd0);
    chk({tag, "_rvld"}, 64'(rsp_valid), 64'd0);
    chk({tag, "_rdat"}, 64'(rsp_data), 64'd0);
    chk({tag, "_rerr"}, 64'(rsp_err), 64'd0);
    chk({tag, "_unexp"}, 64'(err_unexpected), 64'd0);
    chk({tag, "_macc"}, 64'(MRespAccept), 64'd1);
    chk({tag, "_busy"}, 64'(busy), 64'd0);
    chk({tag, "_rdy"}, 64'(req_ready), 64'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: observed no finish expected finish before 200us");
    $fatal(1);
  end

  initial begin
    reset = 1'b1; EnableClk = 1'b1; req_valid = 1'b0; req_write = 1'b0;
    req_addr = '0; req_wdata = '0; rsp_ready = 1'b0;
    SCmdAccept = 1'b0; SDataAccept = 1'b0; SResp = 2'b00; SData = '0;
    tick();
    tick();
    reset = 1'b0;
    check_reset_state("rst");

    // Read with command stall, then a DVA response.
    req_valid = 1'b1; req_write = 1'b0; req_addr = 64'h10;
    tick();
    req_valid = 1'b0;
    chk("rd_not_early", 64'(MCmd), 64'd0);
    tick();
    for (int k = 0; k < 3; k++) begin
      chk("rd_hold_cmd", 64'(MCmd), 64'd2);
      chk("rd_hold_addr", MAddr, 64'h10);
      if (k < 2) tick();
    end
    SCmdAccept = 1'b1;
    tick();
    SCmdAccept = 1'b0;
    chk("rd_after_acc", 64'(MCmd), 64'd0);
    chk("rd_busy_outst", 64'(busy), 64'd1);
    SResp = 2'b01; SData = 8'hA5; rsp_q.push_back({1'b0, 8'hA5});
    tick();
    SResp = 2'b00;
    check_rsp("rd_rsp");
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
    chk("rd_drain", 64'(rsp_valid), 64'd0);
    chk("rd_idle_busy", 64'(busy), 64'd0);

    // Split write: command accepted in cycle 1, data in cycle 3.
    req_valid = 1'b1; req_write = 1'b1; req_addr = 64'h20; req_wdata = 8'h3C;
    tick();
    req_valid = 1'b0;
    tick();
    chk("wr_c1_cmd", 64'(MCmd), 64'd1);
    chk("wr_c1_addr", MAddr, 64'h20);
    chk("wr_c1_data", 64'(MData), 64'h3C);
    chk("wr_c1_dv", 64'(MDataValid), 64'd1);
    SCmdAccept = 1'b1;
    tick();
    SCmdAccept = 1'b0;
    chk("wr_c2_cmd", 64'(MCmd), 64'd0);
    chk("wr_c2_dv", 64'(MDataValid), 64'd1);
    chk("wr_c2_data", 64'(MData), 64'h3C);
    tick();
    chk("wr_c3_cmd", 64'(MCmd), 64'd0);
    chk("wr_c3_dv", 64'(MDataValid), 64'd1);
    SDataAccept = 1'b1;
    tick();
    SDataAccept = 1'b0;
    chk("wr_done_dv", 64'(MDataValid), 64'd0);
    chk("wr_done_data", 64'(MData), 64'd0);
    chk("wr_done_busy", 64'(busy), 64'd0);

    // Six reads against a limit of four outstanding.
    SCmdAccept = 1'b1; rd_cnt = 0; first_rd = -1; last_rd = -1;
    for (int i = 0; i < 12; i++) begin
      if (i < 6) begin
        req_valid = 1'b1; req_write = 1'b0; req_addr = 64'h100 + 64'(i);
        addr_q.push_back(64'h100 + 64'(i));
      end else begin
        req_valid = 1'b0;
      end
      tick();
      if (MCmd == 3'b010) begin
        rd_cnt++;
        if (first_rd < 0) first_rd = i;
        last_rd = i;
        if (addr_q.size() > 0) chk("lim_addr", MAddr, addr_q.pop_front());
      end
    end
    req_valid = 1'b0;
    chk("lim_count", 64'(rd_cnt), 64'd4);
    chk("lim_consec", 64'(last_rd - first_rd), 64'd3);
    chk("lim_stall", 64'(MCmd), 64'd0);
    rsp_ready = 1'b1; SResp = 2'b01; SData = 8'h11; rsp_q.push_back({1'b0, 8'h11});
    tick();
    SResp = 2'b00;
    chk("rel_cmd", 64'(MCmd), 64'd2);
    chk("rel_addr", MAddr, addr_q.pop_front());
    check_rsp("rel_rsp");
    tick();
    chk("rel_stall_again", 64'(MCmd), 64'd0);

    // Response backpressure: two responses while the bridge holds rsp_ready low.
    rsp_ready = 1'b0;
    SResp = 2'b01; SData = 8'h22; rsp_q.push_back({1'b0, 8'h22});
    tick();
    chk("bp_macc0", 64'(MRespAccept), 64'd0);
    chk("bp_next_rd", MAddr, addr_q.pop_front());
    SResp = 2'b11; SData = 8'h33; rsp_q.push_back({1'b1, 8'h33});
    tick();
    check_rsp("bp_first");
    chk("bp_macc_held", 64'(MRespAccept), 64'd0);
    rsp_ready = 1'b1;
    #1;
    chk("bp_macc1", 64'(MRespAccept), 64'd1);
    tick();
    SResp = 2'b00; rsp_ready = 1'b0;
    check_rsp("bp_second");
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0; SCmdAccept = 1'b0;
    chk("bp_drain", 64'(rsp_valid), 64'd0);
    chk("bp_no_unexp", 64'(err_unexpected), 64'd0);

    // Fill the FIFO with the OCP side disabled, issue one, then reset mid-issue.
    reset = 1'b1;
    tick();
    reset = 1'b0;
    EnableClk = 1'b0;
    for (int i = 0; i < 4; i++) begin
      req_valid = 1'b1; req_write = 1'b1;
      req_addr = 64'h40 + 64'(i); req_wdata = 8'h50 + 8'(i);
      tick();
      chk("gate_idle", 64'(MCmd), 64'd0);
      chk("gate_rdy", 64'(req_ready), (i < 3) ? 64'd1 : 64'd0);
    end
    req_valid = 1'b0;
    tick();
    chk("gate_still_idle", 64'(MCmd), 64'd0);
    EnableClk = 1'b1;
    tick();
    chk("issue_cmd", 64'(MCmd), 64'd1);
    chk("issue_addr", MAddr, 64'h40);
    chk("issue_data", 64'(MData), 64'h50);
    chk("issue_rdy", 64'(req_ready), 64'd1);
    EnableClk = 1'b0; reset = 1'b1;
    tick();
    reset = 1'b0;
    check_reset_state("midrst");

    // Response with nothing outstanding after reset.
    EnableClk = 1'b1;
    SResp = 2'b01; SData = 8'h77; rsp_q.push_back({1'b0, 8'h77});
    tick();
    SResp = 2'b00;
    chk("unexp_set", 64'(err_unexpected), 64'd1);
    check_rsp("unexp_rsp");
    chk("unexp_no_underflow", 64'(busy), 64'd0);
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
    chk("unexp_drain", 64'(rsp_valid), 64'd0);
    chk("unexp_sticky", 64'(err_unexpected), 64'd1);

    chk("sb_empty", 64'(rsp_q.size()), 64'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
